// File: rtl/tbm_multiport.sv
// Multi-port buffer memory: NUM_PORTS requesters share one word array through a
// round-robin arbiter, one access per cycle, with per-port registered read data.
module tbm_multiport #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        cs,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] address,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        ready,
    output logic [NUM_PORTS-1:0]        rvalid,
    output logic [NUM_PORTS*DATA_W-1:0] rdata,
    output logic [NUM_PORTS-1:0]        err
);

    localparam int RR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [RR_W-1:0] LAST_PORT = RR_W'(NUM_PORTS - 1);

    logic [RR_W-1:0]   rr_reg;
    logic [RR_W-1:0]   rr_next;
    logic              grant_found;
    logic [RR_W-1:0]   grant_idx;
    logic              accept;

    logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              in_range;
    logic [IDX_W-1:0]  mem_idx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_reg;
    logic              rd_zero_reg;
    logic [DATA_W-1:0] rd_value;
    logic [NUM_PORTS-1:0] rvalid_reg;
    logic [NUM_PORTS-1:0] err_reg;

    // Two passes: ports at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!grant_found && cs[j] && (RR_W'(j) >= rr_reg)) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'(j);
            end
        end
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!grant_found && cs[j] && (RR_W'(j) < rr_reg)) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'(j);
            end
        end
    end

    assign accept = grant_found & ~reset;

    always_comb begin
        rr_next = rr_reg;
        if (accept) begin
            rr_next = (grant_idx == LAST_PORT) ? '0 : grant_idx + RR_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port_in
            assign addr_arr[gi]  = address[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
            assign ready[gi]     = accept && (grant_idx == RR_W'(gi));
        end
    endgenerate

    assign sel_addr  = addr_arr[grant_idx];
    assign sel_wdata = wdata_arr[grant_idx];
    assign sel_we    = we[grant_idx];
    assign mem_idx   = sel_addr[IDX_W-1:0];

    // Out of range means any bit above the index field is set; no wrap-around.
    generate
        if (ADDR_W > IDX_W) begin : g_range_chk
            assign in_range = (sel_addr[ADDR_W-1:IDX_W] == '0);
        end else begin : g_range_all
            assign in_range = 1'b1;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_reg     <= '0;
            rvalid_reg <= '0;
            err_reg    <= '0;
        end else begin
            rr_reg     <= rr_next;
            rvalid_reg <= ready & {NUM_PORTS{~sel_we}};
            err_reg    <= ready & {NUM_PORTS{~in_range}};
        end
    end

    // Storage and its single registered read port; deliberately not reset.
    always_ff @(posedge clock) begin
        if (accept && sel_we && in_range) begin
            mem[mem_idx] <= sel_wdata;
        end
        if (accept && !sel_we) begin
            rd_word_reg <= mem[mem_idx];
            rd_zero_reg <= ~in_range;
        end
    end

    assign rd_value = rd_zero_reg ? '0 : rd_word_reg;

    // The shared read register is presented during the valid cycle and then
    // captured per port so each port's rdata holds until its own next read.
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port_out
            logic [DATA_W-1:0] hold_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    hold_reg <= '0;
                end else if (rvalid_reg[gi]) begin
                    hold_reg <= rd_value;
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = reset ? '0 :
                                                (rvalid_reg[gi] ? rd_value : hold_reg);
        end
    endgenerate

    assign rvalid = rvalid_reg & {NUM_PORTS{~reset}};
    assign err    = err_reg & {NUM_PORTS{~reset}};

endmodule

// File: tb/tb_tbm_multiport.sv
// Directed bench for tbm_multiport: a transaction-level model checked every cycle,
// plus literal expectations from the test plan.
module tb_tbm_multiport;

    localparam int NP    = 2;
    localparam int DW    = 256;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;

    logic             clock = 1'b0;
    logic             reset;
    logic [NP-1:0]    cs;
    logic [NP-1:0]    we;
    logic [NP*AW-1:0] address;
    logic [NP*DW-1:0] wdata;
    logic [NP-1:0]    ready;
    logic [NP-1:0]    rvalid;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    err;

    int errors = 0;
    int checks = 0;

    tbm_multiport #(
        .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .cs(cs), .we(we), .address(address),
        .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk_bits(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Transaction-level model: which port wins, what memory holds, what each port shows.
    int            rr_m = 0;
    logic [NP-1:0] rv_m = '0;
    logic [NP-1:0] er_m = '0;
    logic [DW-1:0] rd_m [NP];
    bit            known_m [NP];
    logic [DW-1:0] mem_m [int];

    function automatic int pick();
        for (int k = 0; k < NP; k++) begin
            int j;
            j = (rr_m + k) % NP;
            if (cs[j] === 1'b1) return j;
        end
        return -1;
    endfunction

    always @(posedge clock) begin : model_update
        int g;
        int ai;
        logic [AW-1:0] a;
        logic [NP-1:0] nv;
        logic [NP-1:0] ne;
        g  = pick();
        nv = '0;
        ne = '0;
        if (reset) begin
            rr_m <= 0;
            for (int p = 0; p < NP; p++) begin
                rd_m[p]    <= '0;
                known_m[p] <= 1'b1;
            end
        end else if (g >= 0) begin
            a  = address[g*AW +: AW];
            ai = int'(a);
            $display("txn port=%0d %s addr=%0d data=%h", g, we[g] ? "write" : "read ",
                     a, wdata[g*DW +: DW]);
            if (we[g]) begin
                if (a < DEPTH) mem_m[ai] = wdata[g*DW +: DW];
                else ne[g] = 1'b1;
            end else begin
                nv[g] = 1'b1;
                if (a >= DEPTH) begin
                    ne[g]      = 1'b1;
                    rd_m[g]    <= '0;
                    known_m[g] <= 1'b1;
                end else if (mem_m.exists(ai)) begin
                    rd_m[g]    <= mem_m[ai];
                    known_m[g] <= 1'b1;
                end else begin
                    known_m[g] <= 1'b0;
                end
            end
            rr_m <= (g + 1) % NP;
        end
        rv_m <= nv;
        er_m <= ne;
    end

    always @(negedge clock) begin : model_compare
        int g;
        logic [NP-1:0] exp_ready;
        exp_ready = '0;
        if (!reset) begin
            g = pick();
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        chk_bits("ready", ready, exp_ready);
        chk_bits("rvalid", rvalid, reset ? '0 : rv_m);
        chk_bits("err", err, reset ? '0 : er_m);
        for (int p = 0; p < NP; p++) begin
            if (reset) chk_word($sformatf("rdata%0d_reset", p), rdata[p*DW +: DW], '0);
            else if (known_m[p]) chk_word($sformatf("rdata%0d", p), rdata[p*DW +: DW], rd_m[p]);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n0;
        int n1;
        for (int p = 0; p < NP; p++) begin
            rd_m[p]    = '0;
            known_m[p] = 1'b1;
        end

        // Reset with every port requesting; first grant after release goes to port 0.
        reset   = 1'b1;
        cs      = 2'b11;
        we      = 2'b11;
        address = {32'd2, 32'd0};
        wdata   = {256'h222, 256'h111};
        repeat (3) step();
        reset = 1'b0;
        #3 chk_bits("first_grant", ready, 2'b01);
        step();
        cs = 2'b10;
        #3 chk_bits("second_grant", ready, 2'b10);
        step();
        cs = 2'b00;
        we = 2'b00;

        // Single-port write then read of address 0.
        cs = 2'b01; we = 2'b01; address[31:0] = 32'd0; wdata[255:0] = 256'hFFFF;
        step();
        we = 2'b00;
        step();
        cs = 2'b00;
        #3;
        chk_bits("sp_rvalid", rvalid, 2'b01);
        chk_word("sp_rdata0", rdata[255:0], 256'hFFFF);
        chk_bits("sp_err", err, 2'b00);
        step();

        // Cross-port read-after-write.
        cs = 2'b01; we = 2'b01; address[31:0] = 32'd5; wdata[255:0] = 256'hA5A5;
        step();
        cs = 2'b10; we = 2'b00; address[63:32] = 32'd5;
        step();
        cs = 2'b00;
        #3;
        chk_bits("raw_rvalid", rvalid, 2'b10);
        chk_word("raw_rdata1", rdata[511:256], 256'hA5A5);
        step();

        // Full contention for 10 cycles: strict alternation, 5 reads per port.
        cs = 2'b11; we = 2'b00; address = {32'd5, 32'd0};
        n0 = 0; n1 = 0;
        for (int k = 0; k < 10; k++) begin
            #3;
            chk_bits($sformatf("fair_grant%0d", k), ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            n0 += int'(rvalid[0]);
            n1 += int'(rvalid[1]);
            step();
        end
        cs = 2'b00;
        #3;
        n0 += int'(rvalid[0]);
        n1 += int'(rvalid[1]);
        chk_int("fair_pulses0", n0, 5);
        chk_int("fair_pulses1", n1, 5);
        step();

        // Last valid address DEPTH-1.
        cs = 2'b01; we = 2'b01; address[31:0] = 32'd1023; wdata[255:0] = 256'h3FF;
        step();
        we = 2'b00;
        step();
        cs = 2'b00;
        #3;
        chk_bits("top_err", err, 2'b00);
        chk_word("top_rdata0", rdata[255:0], 256'h3FF);
        step();

        // Out of range write and read at DEPTH.
        cs = 2'b10; we = 2'b10; address[63:32] = 32'd1024; wdata[511:256] = 256'h1;
        step();
        we = 2'b00;
        #3;
        chk_bits("oor_wr_err", err, 2'b10);
        chk_bits("oor_wr_rvalid", rvalid, 2'b00);
        step();
        cs = 2'b00;
        #3;
        chk_bits("oor_rd_err", err, 2'b10);
        chk_bits("oor_rd_rvalid", rvalid, 2'b10);
        chk_word("oor_rd_rdata1", rdata[511:256], 256'h0);
        step();
        cs = 2'b10; address[63:32] = 32'd0;
        step();
        cs = 2'b00;
        #3;
        chk_bits("oor_after_rvalid", rvalid, 2'b10);
        chk_word("oor_after_rdata1", rdata[511:256], 256'hFFFF);
        step();

        // Reset right after a read is accepted.
        cs = 2'b01; we = 2'b00; address[31:0] = 32'd5;
        step();
        reset = 1'b1;
        cs    = 2'b00;
        #3 chk_bits("midreset_rvalid", rvalid, 2'b00);
        step();
        reset = 1'b0;
        cs    = 2'b11;
        #3 chk_bits("rr_after_reset", ready, 2'b01);
        step();
        cs = 2'b00;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tbm_multiport.md
# tbm_multiport

Parametrised multi-port successor to the single-port `tbm` buffer memory. NUM_PORTS independent requesters share one storage array through a round-robin arbiter. Each port has its own cs/we/address, separate write-data and read-data buses, a grant handshake, a registered read-valid pulse and an out-of-range error pulse. It sits in the XBuffer datapath wherever more than one agent must reach the same wide buffer.

## Interface
- NUM_PORTS, 2: number of requester ports, from 1 to 8.
- DATA_W, 256: word width in bits.
- ADDR_W, 32: width of each port address.
- DEPTH, 1024: number of words; must be a power of two, at most 2^ADDR_W.
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cs  in  NUM_PORTS  per-port request.
- we  in  NUM_PORTS  per-port write (1) / read (0).
- address  in  NUM_PORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  port i at [i*DATA_W +: DATA_W].
- ready  out  NUM_PORTS  one-hot grant (combinational).
- rvalid  out  NUM_PORTS  one-cycle read-data-valid pulse.
- rdata  out  NUM_PORTS*DATA_W  per-port registered read data.
- err  out  NUM_PORTS  one-cycle out-of-range pulse.

## Operation
- **Handshake**
  - A request is accepted in cycle N when cs[i] && ready[i].
  - The requester holds cs, we, address and wdata stable until accepted.
  - Deasserting cs before acceptance withdraws the request without side effects.
- **Arbiter**
  - Round-robin pointer rr, range 0..NUM_PORTS-1.
  - The grant goes to the first asserted cs[j], searching from j = rr upward with wrap.
  - At most one ready bit is high. ready = 0 when no cs is high or reset = 1.
  - On acceptance, rr becomes (granted + 1) mod NUM_PORTS. With no acceptance, rr holds.
- **Address check**
  - Accepted address >= DEPTH: err[i] pulses in cycle N+1.
  - A write is discarded; a read returns rvalid[i] = 1 with rdata[i] = 0.
  - Otherwise the array index is address[log2(DEPTH)-1:0].
- **Write**: mem[index] <= wdata slice at posedge ending cycle N. No rvalid is produced.
- **Read**
  - rdata[i] <= mem[index] and rvalid[i] = 1 in cycle N+1.
  - rdata[i] holds its value until that port's next accepted read.
- **Storage**: the array is not cleared by reset; contents of unwritten words are undefined.
- **Ports**: no combinational path from wdata to rdata.

## Timing
- Reset values: rr = 0, rvalid = 0, err = 0, every rdata slice = 0. ready = 0 while reset is high.
- Read latency is 1 cycle from acceptance. Throughput is one access per cycle across all ports.
- Read-after-write, any ports:
  - A write accepted at N followed by a read to the same address accepted at N+1 returns the new data at N+2.
  - No same-cycle conflict exists, since only one access is granted per cycle.
- Under full contention (all cs high), each port is granted once every NUM_PORTS cycles. Maximum wait is NUM_PORTS-1 cycles.
- NUM_PORTS = 1 degenerates to ready = cs, with rr constant at 0.
- Reset asserted mid-operation:
  - An access accepted in the cycle before reset still updates memory (writes).
  - rvalid and err are forced to 0 while reset is high; the in-flight read pulse is suppressed.
  - rr returns to 0.
- Address exactly DEPTH-1 is valid. DEPTH and above set err; there is no wrap-around into low addresses.

## Test plan
- **Reset defaults.** Assert reset for 3 cycles with all cs high.
  - During reset: ready = 0, rvalid = 0, err = 0, rdata = 0.
  - After release: first grant goes to port 0.
- **Single-port write/read.** Port 0 writes 256'hFFFF to address 0 at N, then reads address 0 at N+1.
  - rvalid[0] = 1 at N+2 with rdata[0] = 256'hFFFF.
  - No err, no rvalid[1].
- **Cross-port RAW.** Port 0 writes 256'hA5A5 to address 5, then port 1 reads address 5 in the following cycle.
  - rdata[1] = 256'hA5A5 one cycle after port 1's acceptance.
- **Contention fairness.** NUM_PORTS = 2, both ports request reads continuously for 10 cycles.
  - Grants alternate 0,1,0,1,...
  - Exactly 5 rvalid pulses per port, each one cycle after its grant.
- **Out of range.** Port 1 writes address DEPTH (1024) with 256'h1, then reads address 1024.
  - err[1] pulses both times; the read returns rvalid[1] = 1 with rdata[1] = 0.
  - A subsequent read of address 0 still returns its prior contents.
- **Reset mid-read.** Read accepted at N, reset high at N+1.
  - rvalid stays 0 at N+1; rr = 0 after release.
